// File: rtl/stream_sort.sv
// rtl/stream_sort.sv - frame insertion sorter over valid/ready streams; SORT_DESCEND_EN selects largest-first order
module stream_sort #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] count,
  output logic             full_close
);

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] slot [DEPTH];
  logic [CNT_W-1:0] pos;
  logic             in_fire, out_fire, close_full;

  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign close_full = (count == CNT_W'(DEPTH - 1));

  // Insertion point: held slots that order at or before the new value (ties land after).
  always_comb begin
    pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef SORT_DESCEND_EN
      if ((CNT_W'(i) < count) && (slot[i] >= in_data)) pos = pos + CNT_W'(1);
`else
      if ((CNT_W'(i) < count) && (slot[i] <= in_data)) pos = pos + CNT_W'(1);
`endif
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  // Next state and handshake outputs; frame closes on in_last or on filling the last slot.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_fire && (in_last || close_full)) state_nx = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = slot[0];
        out_last  = (count == CNT_W'(1));
        if (out_fire && out_last) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  // Sort array: shift up above the insertion point on load, shift down on each drained element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
    end else if (in_fire) begin
      if (pos == '0) slot[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (CNT_W'(i) == pos)     slot[i] <= in_data;
        else if (CNT_W'(i) > pos) slot[i] <= slot[i-1];
      end
    end else if (out_fire) begin
      for (int i = 0; i < DEPTH - 1; i++) slot[i] <= slot[i+1];
      slot[DEPTH-1] <= '0;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        count <= '0;
    else if (in_fire)  count <= count + CNT_W'(1);
    else if (out_fire) count <= count - CNT_W'(1);
  end

  // Sticky flag marking a frame closed by capacity; cleared once the frame is fully drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               full_close <= 1'b0;
    else if (in_fire && close_full)           full_close <= 1'b1;
    else if (out_fire && count == CNT_W'(1))  full_close <= 1'b0;
  end

endmodule

// File: tb/tb_stream_sort.sv
// tb/tb_stream_sort.sv - directed self-checking bench for stream_sort
module tb_stream_sort;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_last;
  logic [7:0] out_data;
  logic [3:0] count;
  logic       full_close;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] bq [$];
  logic [7:0] eq [$];

  stream_sort #(.WIDTH(8), .DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .count(count), .full_close(full_close)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends every beat of bq; in_last on the final beat when last_on_final is set.
  task automatic send_q(input bit last_on_final);
    for (int k = 0; k < bq.size(); k++) begin
      in_valid = 1'b1;
      in_data  = bq[k];
      in_last  = last_on_final && (k == bq.size() - 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h5A;
  endtask

  // Drains with out_ready=1, checking each element of eq, out_last and count.
  task automatic drain_q(input string tag);
    out_ready = 1'b1;
    for (int k = 0; k < eq.size(); k++) begin
      chk($sformatf("%s_valid%0d", tag, k), 32'(out_valid), 32'd1);
      chk($sformatf("%s_data%0d", tag, k), 32'(out_data), 32'(eq[k]));
      chk($sformatf("%s_last%0d", tag, k), 32'(out_last), 32'(k == eq.size() - 1));
      chk($sformatf("%s_cnt%0d", tag, k), 32'(count), 32'(eq.size() - k));
      step();
    end
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    chk({tag, "_valid_off"}, 32'(out_valid), 32'd0);
    chk({tag, "_cnt_zero"}, 32'(count), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full_close", 32'(full_close), 32'd0);
    rst_n = 1'b1;
    step();

    // Frame 5,3,7,1,3 closed by in_last; idle cycle mid-frame accepts nothing.
    out_ready = 1'b1;
    bq = '{8'd5, 8'd3};
    send_q(1'b0);
    step();
    chk("t1_idle_count", 32'(count), 32'd2);
    bq = '{8'd7, 8'd1, 8'd3};
    send_q(1'b1);
    chk("t1_in_ready_low", 32'(in_ready), 32'd0);
    chk("t1_full_close", 32'(full_close), 32'd0);
    eq = '{8'd1, 8'd3, 8'd3, 8'd5, 8'd7};
    drain_q("t1");

    // Eight beats without in_last: closes on capacity.
    bq = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
    send_q(1'b0);
    chk("t2_count7", 32'(count), 32'd7);
    chk("t2_ready7", 32'(in_ready), 32'd1);
    bq = '{8'd1};
    send_q(1'b0);
    chk("t2_full_close", 32'(full_close), 32'd1);
    chk("t2_in_ready_low", 32'(in_ready), 32'd0);
    eq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    drain_q("t2");
    chk("t2_full_close_clr", 32'(full_close), 32'd0);

    // Single-beat frame.
    bq = '{8'hAA};
    send_q(1'b1);
    eq = '{8'hAA};
    drain_q("t3");

    // Back-pressured drain of 2,9,4; in_valid held high during drain must be ignored.
    bq = '{8'd2, 8'd9, 8'd4};
    send_q(1'b1);
    begin
      automatic logic       rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      automatic logic [7:0] dat [5] = '{8'd2, 8'd4, 8'd4, 8'd4, 8'd9};
      automatic logic [3:0] cnt [5] = '{4'd3, 4'd2, 4'd2, 4'd2, 4'd1};
      in_valid = 1'b1; in_data = 8'h00; in_last = 1'b1;
      for (int k = 0; k < 5; k++) begin
        out_ready = rdy[k];
        chk($sformatf("t4_data%0d", k), 32'(out_data), 32'(dat[k]));
        chk($sformatf("t4_cnt%0d", k), 32'(count), 32'(cnt[k]));
        chk($sformatf("t4_last%0d", k), 32'(out_last), 32'(k == 4));
        step();
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk("t4_cnt_end", 32'(count), 32'd0);
      chk("t4_ready_back", 32'(in_ready), 32'd1);
    end

    // Asynchronous reset mid-frame, then a clean frame.
    bq = '{8'd4, 8'd1, 8'd9};
    send_q(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_count", 32'(count), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    bq = '{8'd6, 8'd2};
    send_q(1'b1);
    eq = '{8'd2, 8'd6};
    drain_q("t5");

    // Order with duplicates and extremes; direction follows the build.
    bq = '{8'h10, 8'hFF, 8'h00, 8'h10};
    send_q(1'b1);
`ifdef SORT_DESCEND_EN
    eq = '{8'hFF, 8'h10, 8'h10, 8'h00};
`else
    eq = '{8'h00, 8'h10, 8'h10, 8'hFF};
`endif
    drain_q("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
